// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: single-entry valid/ready buffer feeding the ALU.
// Define ID_EX_FWD_EN to forward EX/WB results into the captured operands.
module id_ex_stage #(
  parameter int XLEN = 64,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_mode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_bus1,
  input  logic [XLEN-1:0] in_bus2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RAW-1:0]  in_rs1,
  input  logic [RAW-1:0]  in_rs2,
  input  logic [RAW-1:0]  in_rd,
  input  logic            in_wen,
  input  logic            flush,
  input  logic            ex_wen,
  input  logic [RAW-1:0]  ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            wb_wen,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_en,
  output logic [1:0]      out_mode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_bus1,
  output logic [XLEN-1:0] out_bus2,
  output logic [XLEN-1:0] out_imm,
  output logic [RAW-1:0]  out_rd,
  output logic            out_wen
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]      state;
  logic [0:0]      state_nxt;
  logic            take;
  logic            give;
  logic            wen_q;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  assign out_valid = (state == FULL);
  assign out_en    = out_valid;
  assign in_ready  = ~out_valid | out_ready | flush;
  assign take      = in_valid & in_ready & ~flush;
  assign give      = out_valid & out_ready;
  // Stale wen may survive a flush or drain; gate it with valid.
  assign out_wen   = wen_q & out_valid;

`ifdef ID_EX_FWD_EN
  function automatic logic [XLEN-1:0] fwd(
    input logic [RAW-1:0]  rs,
    input logic [XLEN-1:0] bus
  );
    logic ex_hit;
    logic wb_hit;
    ex_hit = (rs != '0) & out_valid & ex_wen & (ex_rd == rs);
    wb_hit = (rs != '0) & wb_wen & (wb_rd == rs) & ~ex_hit;
    unique case (1'b1)
      ex_hit:  fwd = ex_data;
      wb_hit:  fwd = wb_data;
      default: fwd = bus;
    endcase
  endfunction

  assign op1 = fwd(in_rs1, in_bus1);
  assign op2 = fwd(in_rs2, in_bus2);
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_wen, ex_rd, ex_data, wb_wen,
                        wb_rd, wb_data, in_rs1, in_rs2};
  assign op1 = in_bus1;
  assign op2 = in_bus2;
`endif

  always_comb begin
    state_nxt = state;
    if (flush)     state_nxt = EMPTY;
    else if (take) state_nxt = FULL;
    else if (give) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_mode   <= '0;
      out_funct3 <= '0;
      out_funct7 <= '0;
      out_bus1   <= '0;
      out_bus2   <= '0;
      out_imm    <= '0;
      out_rd     <= '0;
      wen_q      <= 1'b0;
    end else if (take) begin
      out_mode   <= in_mode;
      out_funct3 <= in_funct3;
      out_funct7 <= in_funct7;
      out_bus1   <= op1;
      out_bus2   <= op2;
      out_imm    <= in_imm;
      out_rd     <= in_rd;
      wen_q      <= in_wen & (in_rd != '0);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, streaming, stall, flush, rd=0
// and operand forwarding (expectations follow ID_EX_FWD_EN).
module tb_id_ex_stage;

  localparam int XLEN = 64;
  localparam int RAW  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_mode;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [XLEN-1:0] in_bus1, in_bus2, in_imm;
  logic [RAW-1:0]  in_rs1, in_rs2, in_rd;
  logic            in_wen;
  logic            flush;
  logic            ex_wen;
  logic [RAW-1:0]  ex_rd;
  logic [XLEN-1:0] ex_data;
  logic            wb_wen;
  logic [RAW-1:0]  wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_en;
  logic [1:0]      out_mode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_bus1, out_bus2, out_imm;
  logic [RAW-1:0]  out_rd;
  logic            out_wen;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] e11, e22, e44;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RAW(RAW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_bus1(in_bus1), .in_bus2(in_bus2), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen),
    .flush(flush),
    .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_data(ex_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_en(out_en),
    .out_mode(out_mode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_bus1(out_bus1), .out_bus2(out_bus2), .out_imm(out_imm),
    .out_rd(out_rd), .out_wen(out_wen)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef ID_EX_FWD_EN
    e11 = 64'h11; e22 = 64'h22; e44 = 64'h44;
`else
    e11 = 64'h33; e22 = 64'h33; e44 = 64'h66;
`endif
    rst = 1'b1;
    in_valid = 0; in_mode = 0; in_funct3 = 0; in_funct7 = 0;
    in_bus1 = 0; in_bus2 = 0; in_imm = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_wen = 0;
    flush = 0; out_ready = 0;
    ex_wen = 0; ex_rd = 0; ex_data = 0;
    wb_wen = 0; wb_rd = 0; wb_data = 0;
    #3;
    chk("rst_valid0", out_valid, 0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_en", out_en, 0);
    chk("rel_bus1", out_bus1, 0);
    chk("rel_wen", out_wen, 0);

    // load one instruction and hold it
    in_valid = 1; in_bus1 = 64'h77; in_bus2 = 64'h55; in_imm = 64'h99;
    in_rd = 3; in_wen = 1; in_mode = 2; in_funct3 = 5; in_funct7 = 7'h20;
    step();
    in_valid = 0;
    chk("ld_valid", out_valid, 1);
    chk("ld_en", out_en, 1);
    chk("ld_bus1", out_bus1, 64'h77);
    chk("ld_bus2", out_bus2, 64'h55);
    chk("ld_imm", out_imm, 64'h99);
    chk("ld_rd", out_rd, 3);
    chk("ld_wen", out_wen, 1);
    chk("ld_mode", out_mode, 2);
    chk("ld_f3", out_funct3, 5);
    chk("ld_f7", out_funct7, 7'h20);
    chk("ld_in_ready", in_ready, 0);

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_en", out_en, 0);
    chk("arst_bus1", out_bus1, 0);
    chk("arst_imm", out_imm, 0);
    chk("arst_rd", out_rd, 0);
    chk("arst_wen", out_wen, 0);
    step();
    rst = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);

    // back-to-back stream
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_bus1 = XLEN'(i); in_rd = RAW'(i);
      step();
      chk("b2b_valid", out_valid, 1);
      chk("b2b_bus1", out_bus1, XLEN'(i));
    end
    in_valid = 0;
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_wen", out_wen, 0);

    // stall
    out_ready = 0; in_valid = 1; in_bus1 = 64'hA5;
    step();
    chk("stall_ld", out_bus1, 64'hA5);
    in_bus1 = 64'hBB;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", in_ready, 0);
      step();
      chk("stall_bus1", out_bus1, 64'hA5);
      chk("stall_valid", out_valid, 1);
    end
    out_ready = 1;
    #1;
    chk("unstall_in_ready", in_ready, 1);
    step();
    chk("unstall_bus1", out_bus1, 64'hBB);

    // flush while full with an incoming instruction
    out_ready = 0; in_bus1 = 64'hCC; flush = 1;
    #1;
    chk("flush_in_ready", in_ready, 1);
    step();
    flush = 0; in_valid = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_en", out_en, 0);
    chk("flush_wen", out_wen, 0);
    step();
    chk("flush_stays", out_valid, 0);

    // rd = 0 suppresses writeback
    out_ready = 1; in_valid = 1; in_rd = 0; in_wen = 1; in_bus1 = 64'h10;
    step();
    chk("rd0_valid", out_valid, 1);
    chk("rd0_wen", out_wen, 0);
    chk("rd0_rd", out_rd, 0);
    in_rd = 5; in_wen = 0;
    step();
    chk("wen0_wen", out_wen, 0);
    chk("wen0_rd", out_rd, 5);

    // forwarding (stage stays FULL so ex match is enabled)
    in_rd = 6; in_wen = 1; in_rs1 = 5; in_bus1 = 64'h33;
    in_bus2 = 64'h66; in_imm = 64'h5A;
    ex_wen = 1; ex_rd = 5; ex_data = 64'h11;
    wb_wen = 1; wb_rd = 5; wb_data = 64'h22;
    step();
    chk("fwd_ex", out_bus1, e11);
    chk("fwd_imm", out_imm, 64'h5A);
    ex_wen = 0;
    step();
    chk("fwd_wb", out_bus1, e22);
    ex_wen = 1; in_rs1 = 0; in_rs2 = 7; wb_rd = 7; wb_data = 64'h44;
    step();
    chk("fwd_rs0", out_bus1, 64'h33);
    chk("fwd_rs2_wb", out_bus2, e44);
    chk("fwd_wen", out_wen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
